// File: rtl/keycode_rx_fifo_if.sv
// Avalon-MM slave bus plus the decoder push port of keycode_rx_fifo.
// The CPU side drives the Avalon strobes; the decoder drives in_valid/in_data.
interface keycode_rx_fifo_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        read_n;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        irq;

    modport slave (
        input  address, chipselect, read_n, write_n, writedata, in_valid, in_data,
        output readdata, in_ready, irq
    );

    modport master (
        output address, chipselect, read_n, write_n, writedata, in_valid, in_data,
        input  readdata, in_ready, irq
    );
endinterface

// File: rtl/keycode_rx_fifo.sv
// Keycode FIFO from the key decoder to the NIOS over Avalon-MM; readdata is combinational (latency 0),
// the decoder cannot stall so pushes into a full FIFO are dropped and flag overflow. KEYCODE_RX_DEDUP_EN adds a repeat filter.
module keycode_rx_fifo #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic               clk,
    input  logic               reset,
    keycode_rx_fifo_if.slave   bus
);

    localparam int                 CNT_W     = PTR_W + 1;
    localparam logic [PTR_W-1:0]   PTR_ONE   = PTR_W'(1);
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]   CNT_FULL  = CNT_W'(DEPTH);
    localparam logic [1:0]         A_DATA    = 2'd0;
    localparam logic [1:0]         A_STATUS  = 2'd1;
    localparam logic [1:0]         A_CONTROL = 2'd2;

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic             irq_en;

    logic rd, wr;
    logic full, empty;
    logic pop, flush, dup;
    logic push_ok, ovf_set, ovf_clr;
    logic [7:0] head;
    logic [4:0] count5;

    assign rd    = bus.chipselect & ~bus.read_n;
    assign wr    = bus.chipselect & ~bus.write_n;
    assign full  = (count == CNT_FULL);
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    assign pop     = rd & (bus.address == A_DATA) & ~empty;
    assign flush   = wr & (bus.address == A_CONTROL) & bus.writedata[1];
    assign ovf_clr = wr & (bus.address == A_STATUS) & bus.writedata[7];

    // A pop on the same edge frees a slot, so a push into a full FIFO still lands.
    assign push_ok = bus.in_valid & ~dup & ~flush & (~full | pop);
    assign ovf_set = bus.in_valid & ~dup & ~flush & full & ~pop;

`ifdef KEYCODE_RX_DEDUP_EN
    logic [7:0] last_code;
    logic       last_valid;

    assign dup = last_valid & (bus.in_data == last_code);

    // A release code (8'h00) re-arms the filter so the next press of the same key gets through.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            last_code  <= 8'h00;
            last_valid <= 1'b0;
        end else if (push_ok) begin
            last_code  <= bus.in_data;
            last_valid <= |bus.in_data;
        end
    end
`else
    assign dup = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= bus.in_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            unique case ({push_ok, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Set beats clear when both land on the same edge.
    always_ff @(posedge clk) begin
        if (reset)
            overflow <= 1'b0;
        else if (ovf_set)
            overflow <= 1'b1;
        else if (ovf_clr)
            overflow <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset)
            irq_en <= 1'b0;
        else if (wr && bus.address == A_CONTROL)
            irq_en <= bus.writedata[0];
    end

    generate
        if (CNT_W >= 5) begin : g_cnt_trunc
            assign count5 = count[4:0];
        end else begin : g_cnt_ext
            assign count5 = {{(5-CNT_W){1'b0}}, count};
        end
    endgenerate

    always_comb begin
        bus.readdata = 32'h0;
        unique case (bus.address)
            A_DATA:    bus.readdata = empty ? 32'h0 : {23'b0, 1'b1, head};
            A_STATUS:  bus.readdata = {24'b0, overflow, full, empty, count5};
            A_CONTROL: bus.readdata = {30'b0, 1'b0, irq_en};
            default:   bus.readdata = 32'h0;
        endcase
    end

    assign bus.in_ready = ~full;
    assign bus.irq      = irq_en & (~empty | overflow);

    logic unused_wdata;
    assign unused_wdata = ^{bus.writedata[31:8], bus.writedata[6:2]};

endmodule

// File: tb/tb_keycode_rx_fifo.sv
// Directed bench for keycode_rx_fifo: a queue model checks readdata/in_ready/irq every cycle,
// and the directed sequence pins hand-computed register values.
module tb_keycode_rx_fifo;

    localparam int DEPTH = 8;
`ifdef KEYCODE_RX_DEDUP_EN
    localparam bit DEDUP = 1'b1;
`else
    localparam bit DEDUP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    keycode_rx_fifo_if bus();

    keycode_rx_fifo #(.DEPTH(DEPTH), .PTR_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue plus the software-visible flags.
    logic [7:0] mq[$];
    bit m_ovf, m_irq_en, m_lv, started;
    logic [7:0] m_lc;

    always @(posedge clk) begin
        bit rdv, wrv, flushv, popv, dupv;
        int old_size;
        started = 1'b1;
        if (reset) begin
            mq.delete();
            m_ovf = 0; m_irq_en = 0; m_lv = 0; m_lc = 8'h00;
        end else begin
            rdv    = bus.chipselect && !bus.read_n;
            wrv    = bus.chipselect && !bus.write_n;
            flushv = wrv && bus.address == 2 && bus.writedata[1];
            popv   = rdv && bus.address == 0 && mq.size() > 0;
            if (wrv && bus.address == 2) m_irq_en = bus.writedata[0];
            if (wrv && bus.address == 1 && bus.writedata[7]) m_ovf = 0;
            if (flushv) begin
                mq.delete();
                m_lv = 0; m_lc = 8'h00;
            end else begin
                old_size = mq.size();
                if (popv) void'(mq.pop_front());
                if (bus.in_valid) begin
                    dupv = DEDUP && m_lv && (bus.in_data == m_lc);
                    if (!dupv) begin
                        if (old_size < DEPTH || popv) begin
                            mq.push_back(bus.in_data);
                            m_lc = bus.in_data;
                            m_lv = (bus.in_data != 8'h00);
                        end else begin
                            m_ovf = 1;
                        end
                    end
                end
            end
        end
    end

    function automatic logic [31:0] model_rdata(input logic [1:0] a);
        int n;
        n = mq.size();
        case (a)
            2'd0: return (n == 0) ? 32'h0 : {23'b0, 1'b1, mq[0]};
            2'd1: return {24'b0, m_ovf, (n == DEPTH), (n == 0), 5'(n)};
            2'd2: return {31'b0, m_irq_en};
            default: return 32'h0;
        endcase
    endfunction

    always @(negedge clk) begin
        if (started) begin
            check("cyc_readdata", bus.readdata, model_rdata(bus.address));
            check("cyc_in_ready", {31'b0, bus.in_ready}, {31'b0, (mq.size() != DEPTH)});
            check("cyc_irq", {31'b0, bus.irq}, {31'b0, m_irq_en && (mq.size() != 0 || m_ovf)});
        end
    end

    // All tasks start and end 1 time unit after a rising edge.
    task automatic idle();
        @(posedge clk); #1;
    endtask

    task automatic push(input logic [7:0] code);
        bus.in_valid = 1'b1; bus.in_data = code;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic rd_reg(input logic [1:0] a, output logic [31:0] d);
        bus.address = a; bus.chipselect = 1'b1; bus.read_n = 1'b0;
        @(negedge clk);
        d = bus.readdata;
        @(posedge clk); #1;
        bus.chipselect = 1'b0; bus.read_n = 1'b1;
    endtask

    task automatic rd_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
        logic [31:0] d;
        rd_reg(a, d);
        check(name, d, exp);
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
        bus.address = a; bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.writedata = d;
        @(posedge clk); #1;
        bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = 32'h0;
    endtask

    initial begin
        logic [31:0] d;
        reset = 1'b1;
        bus.address = 2'd0; bus.chipselect = 1'b0; bus.read_n = 1'b1; bus.write_n = 1'b1;
        bus.writedata = 32'h0; bus.in_valid = 1'b0; bus.in_data = 8'h00;
        idle(); idle();
        reset = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_data", bus.readdata, 32'h0);
        check("rst_in_ready", {31'b0, bus.in_ready}, 32'h1);
        check("rst_irq", {31'b0, bus.irq}, 32'h0);
        idle();
        rd_chk("rst_status", 2'd1, 32'h20);

        // Basic ordering
        push(8'h1C); push(8'h32); push(8'h21);
        rd_chk("three_status", 2'd1, 32'h03);
        rd_chk("pop0", 2'd0, 32'h11C);
        rd_chk("pop1", 2'd0, 32'h132);
        rd_chk("pop2", 2'd0, 32'h121);
        rd_chk("pop_empty", 2'd0, 32'h000);
        rd_chk("empty_status", 2'd1, 32'h20);
        rd_chk("addr3", 2'd3, 32'h0);

        // Overflow
        for (int i = 1; i <= 9; i++) push(8'(i));
        rd_chk("ovf_status", 2'd1, 32'hC8);
        check("ovf_in_ready", {31'b0, bus.in_ready}, 32'h0);
        for (int i = 1; i <= 8; i++) rd_chk("ovf_pop", 2'd0, 32'h100 | i);
        wr_reg(2'd1, 32'h80);
        rd_chk("ovf_clr_status", 2'd1, 32'h20);

        // Push + pop on a full FIFO
        for (int i = 0; i < 8; i++) push(8'h11 + 8'(i));
        bus.in_valid = 1'b1; bus.in_data = 8'h55;
        rd_reg(2'd0, d);
        bus.in_valid = 1'b0;
        check("full_pp_head", d, 32'h111);
        rd_chk("full_pp_status", 2'd1, 32'h48);
        for (int i = 1; i < 8; i++) rd_chk("full_pp_pop", 2'd0, 32'h111 + i);
        rd_chk("full_pp_last", 2'd0, 32'h155);

        // Push + pop on an empty FIFO
        bus.in_valid = 1'b1; bus.in_data = 8'h42;
        rd_reg(2'd0, d);
        bus.in_valid = 1'b0;
        check("empty_pp_data", d, 32'h0);
        rd_chk("empty_pp_status", 2'd1, 32'h01);
        rd_chk("empty_pp_pop", 2'd0, 32'h142);

        // IRQ and flush
        wr_reg(2'd2, 32'h1);
        push(8'h1D);
        @(negedge clk);
        check("irq_set", {31'b0, bus.irq}, 32'h1);
        idle();
        rd_chk("irq_pop", 2'd0, 32'h11D);
        @(negedge clk);
        check("irq_clr", {31'b0, bus.irq}, 32'h0);
        idle();
        for (int i = 0; i < 4; i++) push(8'h61 + 8'(i));
        bus.in_valid = 1'b1; bus.in_data = 8'h77;
        wr_reg(2'd2, 32'h3);
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("flush_irq", {31'b0, bus.irq}, 32'h0);
        idle();
        rd_chk("flush_status", 2'd1, 32'h20);
        rd_chk("flush_ctrl", 2'd2, 32'h1);

        // Reset mid-transfer with 5 queued, overflow set, irq_en=1
        for (int i = 0; i < 9; i++) push(8'h30 + 8'(i));
        for (int i = 0; i < 3; i++) rd_chk("pre_rst_pop", 2'd0, 32'h130 + i);
        rd_chk("pre_rst_status", 2'd1, 32'h85);
        bus.address = 2'd0; bus.chipselect = 1'b1; bus.read_n = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = 8'h99;
        reset = 1'b1;
        idle();
        reset = 1'b0;
        bus.chipselect = 1'b0; bus.read_n = 1'b1; bus.in_valid = 1'b0;
        @(negedge clk);
        check("post_rst_data", bus.readdata, 32'h0);
        check("post_rst_irq", {31'b0, bus.irq}, 32'h0);
        check("post_rst_in_ready", {31'b0, bus.in_ready}, 32'h1);
        idle();
        rd_chk("post_rst_status", 2'd1, 32'h20);
        rd_chk("post_rst_ctrl", 2'd2, 32'h0);

`ifdef KEYCODE_RX_DEDUP_EN
        push(8'h1C); push(8'h1C); push(8'h1C); push(8'h00); push(8'h1C);
        rd_chk("dedup_status", 2'd1, 32'h03);
        rd_chk("dedup_pop0", 2'd0, 32'h11C);
        rd_chk("dedup_pop1", 2'd0, 32'h100);
        rd_chk("dedup_pop2", 2'd0, 32'h11C);
`endif

        idle(); idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
